// File: rtl/operand_collector_pkg.sv
// Shared constants for the carry-skip adder datapath: collector state encoding
// and the operand geometry used by the collector, adder top and result serializer.
package operand_collector_pkg;

  localparam int unsigned OP_WIDTH     = 64;
  localparam int unsigned BYTES_PER_OP = 8;

  typedef enum logic [1:0] {
    COLLECT_A = 2'd0,
    COLLECT_B = 2'd1,
    HOLD      = 2'd2
  } state_e;

endpackage

// File: rtl/operand_collector_byte_timeout_timer.sv
// Inter-byte idle counter: clears on every byte (kick) and whenever disabled,
// and flags expiry on the last idle cycle of the allowed window.
module byte_timeout_timer
  import operand_collector_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] timer_q;

  assign expired = enable && !kick && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Expiry clears the count itself so the counter can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (!enable || kick || expired) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TW'(1);
    end
  end

endmodule

// File: rtl/operand_collector.sv
// Assembles two LSB-first operands from a UART byte stream and offers them to
// the adder with a valid/ready handshake; stale partial frames time out.
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int unsigned BYTES_PER_OP   = operand_collector_pkg::BYTES_PER_OP,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [8*BYTES_PER_OP-1:0] op_a,
  output logic [8*BYTES_PER_OP-1:0] op_b,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic                      busy,
  output logic                      overrun,
  output logic                      timeout_err
);

  localparam int unsigned CNT_W = (BYTES_PER_OP > 1) ? $clog2(BYTES_PER_OP) : 1;

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [8*BYTES_PER_OP-1:0] op_a_q;
  logic [8*BYTES_PER_OP-1:0] op_b_q;
  logic                      op_valid_q;
  logic                      busy_q;
  logic                      overrun_q;
  logic                      timeout_err_q;
  logic                      last_byte;
  logic                      tmr_enable;
  logic                      tmr_expired;

  assign last_byte  = (cnt_q == CNT_W'(BYTES_PER_OP - 1));
  assign tmr_enable = busy_q && (state_q != HOLD);

  byte_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (tmr_enable),
    .kick   (rx_valid),
    .expired(tmr_expired)
  );

  // Frame FSM with byte-lane writes; busy and op_valid are decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT_A;
      cnt_q         <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        COLLECT_A, COLLECT_B: begin
          if (rx_valid) begin
            if (state_q == COLLECT_A) begin
              op_a_q[8*cnt_q +: 8] <= rx_data;
            end else begin
              op_b_q[8*cnt_q +: 8] <= rx_data;
            end
            busy_q <= 1'b1;
            if (last_byte) begin
              cnt_q      <= '0;
              state_q    <= (state_q == COLLECT_A) ? COLLECT_B : HOLD;
              op_valid_q <= (state_q == COLLECT_B);
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (tmr_expired) begin
            state_q       <= COLLECT_A;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
          end
        end
        HOLD: begin
          if (op_ready) begin
            // A byte arriving with the handshake starts the next frame at once.
            op_valid_q <= 1'b0;
            state_q    <= COLLECT_A;
            if (rx_valid) begin
              op_a_q[7:0] <= rx_data;
              cnt_q       <= CNT_W'(1);
              busy_q      <= 1'b1;
            end else begin
              cnt_q  <= '0;
              busy_q <= 1'b0;
            end
          end else if (rx_valid) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= COLLECT_A;
          cnt_q      <= '0;
          op_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_valid    = op_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_operand_collector.sv
// Randomized and directed bench for operand_collector against a byte-array
// frame model; every output is compared after every clock edge.
module tb_operand_collector;

  localparam int unsigned TMO = 20;

  logic        clk;
  logic        clk_run;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        op_valid;
  logic        op_ready;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  int checks;
  int errors;

  // Reference model: bytes of the current/last frame, how many are held
  // (16 means a complete frame waits for the consumer), cycle of last byte.
  logic [7:0] mbytes [16];
  int         mcount;
  longint     cyc;
  longint     last_cyc;
  logic       exp_ovr;
  logic       exp_to;

  operand_collector #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .busy       (busy),
    .overrun    (overrun),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model_op(input int base);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mbytes[base + i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mbytes[i] = 8'h00;
    mcount   = 0;
    last_cyc = 0;
    exp_ovr  = 1'b0;
    exp_to   = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    exp_ovr = 1'b0;
    exp_to  = 1'b0;
    if (mcount == 16) begin
      if (r) begin
        mcount = 0;
        if (v) begin
          mbytes[0] = d;
          mcount    = 1;
          last_cyc  = cyc;
        end
      end else if (v) begin
        exp_ovr = 1'b1;
      end
    end else if (v) begin
      mbytes[mcount] = d;
      mcount++;
      last_cyc = cyc;
    end else if (mcount != 0 && (cyc - last_cyc) == longint'(TMO)) begin
      mcount = 0;
      exp_to = 1'b1;
    end
  endtask

  task automatic compare_all();
    check_eq("op_valid", {63'd0, op_valid}, {63'd0, (mcount == 16)});
    check_eq("busy", {63'd0, busy}, {63'd0, (mcount != 0)});
    check_eq("overrun", {63'd0, overrun}, {63'd0, exp_ovr});
    check_eq("timeout_err", {63'd0, timeout_err}, {63'd0, exp_to});
    check_eq("op_a", op_a, model_op(0));
    check_eq("op_b", op_b, model_op(8));
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    rx_valid = v;
    rx_data  = d;
    op_ready = r;
    @(posedge clk);
    cyc++;
    model_step(v, d, r);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [7:0] first, input int gap, input logic r);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, first + 8'(i), r);
      for (int g = 0; g < gap; g++) step(1'b0, 8'h00, r);
    end
  endtask

  initial begin
    int k;
    int seen;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    clk_run  = 1'b1;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    op_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Normal frame, 16-cycle gaps, consumer always ready.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i < 8) ? 8'(i + 1) : 8'(i + 9), 1'b1);
      if (i < 15) for (int g = 0; g < 16; g++) step(1'b0, 8'h00, 1'b1);
    end
    check_eq("norm_a", op_a, 64'h0807060504030201);
    check_eq("norm_b", op_b, 64'h1817161514131211);
    check_eq("norm_valid", {63'd0, op_valid}, 64'd1);
    step(1'b0, 8'h00, 1'b1);
    check_eq("norm_valid_drop", {63'd0, op_valid}, 64'd0);

    // Backpressure: byte dropped in HOLD, then one-cycle accept.
    send_frame(8'h40, 1, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    check_eq("bp_overrun", {63'd0, overrun}, 64'd1);
    check_eq("bp_a_kept", op_a, 64'h4746454443424140);
    step(1'b0, 8'h00, 1'b0);
    check_eq("bp_overrun_pulse", {63'd0, overrun}, 64'd0);
    check_eq("bp_still_valid", {63'd0, op_valid}, 64'd1);
    step(1'b0, 8'h00, 1'b1);
    check_eq("bp_busy", {63'd0, busy}, 64'd0);

    // Handshake and new byte in the same cycle.
    send_frame(8'h60, 0, 1'b0);
    step(1'b1, 8'h5C, 1'b1);
    check_eq("sim_byte0", {56'd0, op_a[7:0]}, 64'h5C);
    check_eq("sim_no_ovr", {63'd0, overrun}, 64'd0);
    check_eq("sim_busy", {63'd0, busy}, 64'd1);

    // Two more bytes make three in A, then idle until timeout.
    step(1'b1, 8'h71, 1'b1);
    step(1'b1, 8'h72, 1'b1);
    seen = 0;
    for (k = 1; k <= 40 && seen == 0; k++) begin
      step(1'b0, 8'h00, 1'b1);
      if (timeout_err) seen = k;
    end
    check_eq("tmo_latency", 64'(seen), 64'(TMO));
    check_eq("tmo_busy", {63'd0, busy}, 64'd0);
    send_frame(8'h90, 0, 1'b1);

    // Byte landing exactly on the expiry cycle is accepted.
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hB0 + 8'(i), 1'b1);
    for (int g = 0; g < TMO - 1; g++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hB3, 1'b1);
    check_eq("bnd_no_tmo", {63'd0, timeout_err}, 64'd0);
    check_eq("bnd_byte3", {56'd0, op_a[31:24]}, 64'hB3);
    for (int i = 4; i < 16; i++) step(1'b1, 8'hB0 + 8'(i), 1'b1);
    check_eq("bnd_frame_b", op_b, 64'hBFBEBDBCBBBAB9B8);

    // Random traffic with occasional long idle bursts around the timeout.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        int len;
        len = $urandom_range(TMO - 3, TMO + 3);
        for (int g = 0; g < len; g++) step(1'b0, 8'h00, 1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    // Asynchronous reset mid-B with the clock stopped.
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 8'hC0 + 8'(i), 1'b1);
    @(negedge clk);
    #1;
    clk_run = 1'b0;
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    check_eq("arst_a", op_a, 64'd0);
    #10;
    rst_n = 1'b1;
    #3;
    clk_run = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 8'hFF, 1'b0);
    check_eq("ff_a", op_a, 64'hFFFFFFFFFFFFFFFF);
    check_eq("ff_b", op_b, 64'hFFFFFFFFFFFFFFFF);
    step(1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
